// File: rtl/demux4_router_if.sv
// Bundle of the demux4_router val/rdy streams: one tagged input stream and
// four output ports. The router sits on the slave side. The producer and the
// consumers sit together on the master side.
interface demux4_router_if #(
  parameter int p_nbits = 32
);
  logic               in_val;
  logic               in_rdy;
  logic [1:0]         in_dest;
  logic [p_nbits-1:0] in_msg;
  logic [3:0]         out_val;
  logic [3:0]         out_rdy;
  logic [p_nbits-1:0] out0_msg;
  logic [p_nbits-1:0] out1_msg;
  logic [p_nbits-1:0] out2_msg;
  logic [p_nbits-1:0] out3_msg;

  modport master (
    output in_val, in_dest, in_msg, out_rdy,
    input  in_rdy, out_val, out0_msg, out1_msg, out2_msg, out3_msg
  );

  modport slave (
    input  in_val, in_dest, in_msg, out_rdy,
    output in_rdy, out_val, out0_msg, out1_msg, out2_msg, out3_msg
  );
endinterface

// File: rtl/demux4_router.sv
// 1-to-4 val/rdy demultiplexer. Each output port has its own one-entry
// register, so a message takes one cycle from input to output. A port that
// is stalled only holds back messages addressed to that port.
module demux4_router #(
  parameter int p_nbits = 32
) (
  input logic            clk,
  input logic            reset,
  demux4_router_if.slave bus
);

  logic [3:0]         full_q;
  logic [3:0]         full_d;
  logic [p_nbits-1:0] data_q [4];
  logic [p_nbits-1:0] data_d [4];
  logic               in_rdy;
  logic               fire;
  logic [3:0]         deq;

  // Accept when the addressed slot is empty or is being drained this cycle.
  // The path from out_rdy to in_rdy lets a full port keep one message per
  // cycle flowing.
  assign in_rdy = !reset && (!full_q[bus.in_dest] || bus.out_rdy[bus.in_dest]);
  assign fire   = bus.in_val && in_rdy;
  assign deq    = full_q & bus.out_rdy;

  // Per-port next state: a dequeue clears the slot and an enqueue sets it.
  // When both happen on the same edge the enqueue wins, so the slot refills.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    full_d = full_q;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
      if (deq[i]) begin
        full_d[i] = 1'b0;
      end
      if (fire && (bus.in_dest == 2'(i))) begin
        full_d[i] = 1'b1;
        data_d[i] = bus.in_msg;
      end
    end
  end

  // Port registers. Reset is asynchronous and discards any buffered messages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      // NOTE: the payload registers are reset too, because the outN_msg outputs must read zero while reset is held.
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples its pre-edge value.
      full_q <= full_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.out_val  = full_q;
  assign bus.out0_msg = data_q[0];
  assign bus.out1_msg = data_q[1];
  assign bus.out2_msg = data_q[2];
  assign bus.out3_msg = data_q[3];

endmodule

// File: tb/tb_demux4_router.sv
// Directed and random checks of demux4_router. Three instances (32, 5 and
// 1 bit wide) share one stimulus stream. Their handshakes do not depend on
// the payload, so one per-port reference queue covers all three.
module tb_demux4_router;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic [1:0]  in_dest;
  logic [31:0] in_msg;
  logic [3:0]  out_rdy;

  int n_checks;
  int n_errors;

  demux4_router_if #(.p_nbits(32)) if32 ();
  demux4_router_if #(.p_nbits(5))  if5 ();
  demux4_router_if #(.p_nbits(1))  if1 ();

  assign if32.in_val  = in_val;
  assign if32.in_dest = in_dest;
  assign if32.in_msg  = in_msg;
  assign if32.out_rdy = out_rdy;
  assign if5.in_val   = in_val;
  assign if5.in_dest  = in_dest;
  assign if5.in_msg   = in_msg[4:0];
  assign if5.out_rdy  = out_rdy;
  assign if1.in_val   = in_val;
  assign if1.in_dest  = in_dest;
  assign if1.in_msg   = in_msg[0];
  assign if1.out_rdy  = out_rdy;

  demux4_router #(.p_nbits(32)) u_dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
  demux4_router #(.p_nbits(5))  u_dut5  (.clk(clk), .reset(reset), .bus(if5.slave));
  demux4_router #(.p_nbits(1))  u_dut1  (.clk(clk), .reset(reset), .bus(if1.slave));

  logic [31:0] m32 [4];
  logic [4:0]  m5  [4];
  logic        m1  [4];

  assign m32[0] = if32.out0_msg;
  assign m32[1] = if32.out1_msg;
  assign m32[2] = if32.out2_msg;
  assign m32[3] = if32.out3_msg;
  assign m5[0]  = if5.out0_msg;
  assign m5[1]  = if5.out1_msg;
  assign m5[2]  = if5.out2_msg;
  assign m5[3]  = if5.out3_msg;
  assign m1[0]  = if1.out0_msg;
  assign m1[1]  = if1.out1_msg;
  assign m1[2]  = if1.out2_msg;
  assign m1[3]  = if1.out3_msg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Per-port reference queues for the random phase.
  logic [31:0] ref_q [4][$];
  logic [31:0] steer_msg [4];
  logic [31:0] front;
  logic        exp_rdy;
  logic        stalled;
  logic [3:0]  exp_val;

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset with traffic offered: nothing is accepted and all outputs read zero.
    reset   = 1'b1;
    in_val  = 1'b1;
    in_dest = 2'd0;
    in_msg  = 32'hFFFF_FFFF;
    out_rdy = 4'b1111;
    #1;
    check("reset in_rdy32", 64'(if32.in_rdy), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset out_val32", 64'(if32.out_val), 64'h0);
    check("reset out_val5", 64'(if5.out_val), 64'h0);
    check("reset out_val1", 64'(if1.out_val), 64'h0);
    check("reset in_rdy32 held", 64'(if32.in_rdy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset msg32[%0d]", i), 64'(m32[i]), 64'h0);
      check($sformatf("reset msg5[%0d]", i), 64'(m5[i]), 64'h0);
    end

    reset  = 1'b0;
    in_val = 1'b0;
    #1;
    check("post-reset in_rdy", 64'(if32.in_rdy), 64'd1);

    // Steering: one message to each port, all consumers ready.
    steer_msg[0] = 32'hA0;
    steer_msg[1] = 32'hB1;
    steer_msg[2] = 32'hC2;
    steer_msg[3] = 32'hD3;
    for (int i = 0; i < 4; i++) begin
      in_val  = 1'b1;
      in_dest = 2'(i);
      in_msg  = steer_msg[i];
      #1;
      check($sformatf("steer in_rdy[%0d]", i), 64'(if32.in_rdy), 64'd1);
      @(posedge clk); #1;
      check($sformatf("steer out_val[%0d]", i), 64'(if32.out_val), 64'(4'b0001 << i));
      check($sformatf("steer msg[%0d]", i), 64'(m32[i]), 64'(steer_msg[i]));
    end
    in_val = 1'b0;
    @(posedge clk); #1;
    check("steer drained", 64'(if32.out_val), 64'h0);

    // Full stall on port 2, released through the out_rdy pass-through.
    out_rdy = 4'b0000;
    in_val  = 1'b1;
    in_dest = 2'd2;
    in_msg  = 32'h11;
    @(posedge clk); #1;
    check("stall out_val", 64'(if32.out_val), 64'b0100);
    check("stall msg first", 64'(m32[2]), 64'h11);
    in_msg = 32'h22;
    #1;
    check("stall in_rdy low", 64'(if32.in_rdy), 64'd0);
    @(posedge clk); #1;
    check("stall msg held", 64'(m32[2]), 64'h11);
    check("stall val held", 64'(if32.out_val), 64'b0100);
    out_rdy = 4'b0100;
    #1;
    check("stall release in_rdy", 64'(if32.in_rdy), 64'd1);
    @(posedge clk); #1;
    check("stall msg second", 64'(m32[2]), 64'h22);
    check("stall val second", 64'(if32.out_val), 64'b0100);

    // Isolation: port 1 blocked, port 3 still accepts.
    out_rdy = 4'b0000;
    in_dest = 2'd1;
    in_msg  = 32'h44;
    @(posedge clk); #1;
    check("iso fill port1", 64'(if32.out_val), 64'b0110);
    in_dest = 2'd3;
    in_msg  = 32'h33;
    #1;
    check("iso in_rdy port3", 64'(if32.in_rdy), 64'd1);
    @(posedge clk); #1;
    check("iso out_val", 64'(if32.out_val), 64'b1110);
    check("iso msg3", 64'(m32[3]), 64'h33);
    check("iso msg1 held", 64'(m32[1]), 64'h44);
    in_val  = 1'b0;
    in_dest = 2'd1;
    #1;
    check("iso in_rdy port1 blocked", 64'(if32.in_rdy), 64'd0);
    out_rdy = 4'b1111;
    @(posedge clk); #1;
    check("iso drained", 64'(if32.out_val), 64'h0);

    // Back-to-back enqueue and dequeue on port 0.
    in_val  = 1'b1;
    in_dest = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      in_msg = 32'(k);
      @(posedge clk); #1;
      check($sformatf("stream val[%0d]", k), 64'(if32.out_val), 64'b0001);
      check($sformatf("stream msg[%0d]", k), 64'(m32[0]), 64'(k));
    end
    in_val = 1'b0;
    @(posedge clk); #1;
    check("stream drained", 64'(if32.out_val), 64'h0);

    // Random traffic against the per-port reference queues.
    stalled = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc == 100) begin
        // Mid-run reset: buffered messages are dropped, nothing transfers.
        reset  = 1'b1;
        in_val = 1'b1;
        for (int i = 0; i < 4; i++) ref_q[i].delete();
        stalled = 1'b0;
        #1;
        check("midreset out_val32", 64'(if32.out_val), 64'h0);
        check("midreset out_val5", 64'(if5.out_val), 64'h0);
        check("midreset out_val1", 64'(if1.out_val), 64'h0);
        check("midreset in_rdy", 64'(if32.in_rdy), 64'd0);
        @(posedge clk); #1;
        check("midreset held out_val", 64'(if32.out_val), 64'h0);
        reset  = 1'b0;
        in_val = 1'b0;
      end

      // Outputs against the model.
      for (int i = 0; i < 4; i++) exp_val[i] = (ref_q[i].size() != 0);
      check($sformatf("rnd%0d out_val32", cyc), 64'(if32.out_val), 64'(exp_val));
      check($sformatf("rnd%0d out_val5", cyc), 64'(if5.out_val), 64'(exp_val));
      check($sformatf("rnd%0d out_val1", cyc), 64'(if1.out_val), 64'(exp_val));
      for (int i = 0; i < 4; i++) begin
        if (exp_val[i]) begin
          front = ref_q[i][0];
          check($sformatf("rnd%0d msg32[%0d]", cyc, i), 64'(m32[i]), 64'(front));
          check($sformatf("rnd%0d msg5[%0d]", cyc, i), 64'(m5[i]), 64'(front[4:0]));
          check($sformatf("rnd%0d msg1[%0d]", cyc, i), 64'(m1[i]), 64'(front[0]));
        end
      end

      // New stimulus. A stalled offer stays unchanged until it is taken.
      if (!stalled) begin
        in_val  = 1'($urandom_range(0, 1));
        in_dest = 2'($urandom_range(0, 3));
        in_msg  = $urandom();
      end
      out_rdy = 4'($urandom_range(0, 15));
      #1;
      exp_rdy = (ref_q[in_dest].size() == 0) || out_rdy[in_dest];
      check($sformatf("rnd%0d in_rdy32", cyc), 64'(if32.in_rdy), 64'(exp_rdy));
      check($sformatf("rnd%0d in_rdy5", cyc), 64'(if5.in_rdy), 64'(exp_rdy));
      check($sformatf("rnd%0d in_rdy1", cyc), 64'(if1.in_rdy), 64'(exp_rdy));
      stalled = in_val && !exp_rdy;

      // Model update for the coming edge: drain first, then fill.
      for (int i = 0; i < 4; i++) begin
        if (ref_q[i].size() != 0 && out_rdy[i]) void'(ref_q[i].pop_front());
      end
      if (in_val && exp_rdy) ref_q[in_dest].push_back(in_msg);

      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
